// File: rtl/vpa_if.sv
// Handshake bundle between the TDC readout sequencer and its driver/consumer.
// Range-limit inputs dmin/dmax are present only when VPA_RANGE_CHK_EN is defined.
interface vpa_if #(
    parameter int CNT_W = 7,
    parameter int ACC_W = 16
);
    logic             en;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] delta;
    logic [ACC_W-1:0] phase;
    logic             valid;
    logic             stall;
    logic             busy;
    logic             out_of_range;
`ifdef VPA_RANGE_CHK_EN
    logic [CNT_W-1:0] dmin;
    logic [CNT_W-1:0] dmax;

    modport master (
        output en, count, dmin, dmax,
        input  delta, phase, valid, stall, busy, out_of_range
    );
    modport slave (
        input  en, count, dmin, dmax,
        output delta, phase, valid, stall, busy, out_of_range
    );
`else
    modport master (
        output en, count,
        input  delta, phase, valid, stall, busy, out_of_range
    );
    modport slave (
        input  en, count,
        output delta, phase, valid, stall, busy, out_of_range
    );
`endif
endinterface

// File: rtl/vpa_ctrl.sv
// TDC ripple-counter readout: per-reference-cycle modulo increment, variable-phase
// accumulation, warm-up discard and sticky CKV stall flag; 1-cycle registered latency,
// no backpressure (one sample per clk). Optional range check under VPA_RANGE_CHK_EN.
module vpa_ctrl #(
    parameter int CNT_W     = 7,
    parameter int ACC_W     = 16,
    parameter int WARMUP    = 4,
    parameter int STALL_MAX = 3
) (
    input logic clk,
    input logic rst_n,
    vpa_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    localparam logic [3:0] WARM_LAST = 4'(WARMUP - 1);
    localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);

    state_t           state;
    logic [CNT_W-1:0] prev;
    logic [3:0]       warm_cnt;
    logic [3:0]       stall_cnt;
    logic [CNT_W-1:0] delta_q;
    logic [ACC_W-1:0] phase_q;
    logic             valid_q;
    logic             stall_q;
    logic             busy_q;

    logic [CNT_W-1:0] d;
    logic [ACC_W-1:0] phase_sum;
    logic [3:0]       warm_inc;
    logic [3:0]       stall_inc;

    // Counter wrap needs no special case: the truncated subtract is the true increment.
    assign d         = CNT_W'(bus.count - prev);
    assign phase_sum = phase_q + {{(ACC_W-CNT_W){1'b0}}, d};
    assign warm_inc  = warm_cnt + 4'd1;
    assign stall_inc = (stall_cnt == 4'hF) ? stall_cnt : stall_cnt + 4'd1;

`ifdef VPA_RANGE_CHK_EN
    logic oor_q;
    logic d_bad;
    assign d_bad = (d < bus.dmin) || (d > bus.dmax);
    assign bus.out_of_range = oor_q;
`else
    assign bus.out_of_range = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prev      <= '0;
            warm_cnt  <= '0;
            stall_cnt <= '0;
            delta_q   <= '0;
            phase_q   <= '0;
            valid_q   <= 1'b0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef VPA_RANGE_CHK_EN
            oor_q     <= 1'b0;
`endif
        end else begin
            prev <= bus.count;
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.en) begin
                        warm_cnt  <= '0;
                        stall_cnt <= '0;
                        stall_q   <= 1'b0;
                        phase_q   <= '0;
`ifdef VPA_RANGE_CHK_EN
                        oor_q     <= 1'b0;
`endif
                        // A one-cycle warm-up is satisfied by this edge alone.
                        state  <= (WARMUP == 1) ? ST_RUN : ST_WARMUP;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WARMUP: begin
                    valid_q <= 1'b0;
                    if (!bus.en) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        warm_cnt <= warm_inc;
                        busy_q   <= 1'b1;
                        if (warm_inc == WARM_LAST) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.en) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        delta_q <= d;
                        phase_q <= phase_sum;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        if (d == '0) begin
                            stall_cnt <= stall_inc;
                            if (stall_inc >= STALL_LIM) begin
                                stall_q <= 1'b1;
                            end
                        end else begin
                            stall_cnt <= '0;
                        end
`ifdef VPA_RANGE_CHK_EN
                        if (d_bad) begin
                            oor_q <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.delta = delta_q;
    assign bus.phase = phase_q;
    assign bus.valid = valid_q;
    assign bus.stall = stall_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_vpa_ctrl.sv
// Bench for vpa_ctrl: vector table for reset/nominal/wrap/stall/en sequencing,
// plus hand sequences for mid-run reset, accumulator wrap and the range check.
module tb_vpa_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [6:0] cv;

    vpa_if #(.CNT_W(7), .ACC_W(16)) bus ();

    vpa_ctrl #(.CNT_W(7), .ACC_W(16), .WARMUP(4), .STALL_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [6:0]  count;
        logic [6:0]  delta;
        logic [15:0] phase;
        logic        valid;
        logic        stall;
        logic        busy;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [6:0] c);
        @(negedge clk);
        rst_n     = r;
        bus.en    = e;
        bus.count = c;
        @(posedge clk);
        #1;
    endtask

    // IDLE->WARMUP edge plus three warm-up edges, count advancing by s each edge.
    task automatic start_run(input int s);
        step(1'b1, 1'b1, cv);
        for (int i = 0; i < 3; i++) begin
            cv = cv + 7'(s);
            step(1'b1, 1'b1, cv);
        end
    endtask

    task automatic run_n(input int n, input int s);
        for (int i = 0; i < n; i++) begin
            cv = cv + 7'(s);
            step(1'b1, 1'b1, cv);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.count = '0;
`ifdef VPA_RANGE_CHK_EN
        bus.dmin  = 7'd0;
        bus.dmax  = 7'd127;
`endif
        //            rst en cnt   delta phase  vld stl busy
        vecs[0]  = '{1'b0, 1'b0, 7'd0,   7'd0,  16'd0,   1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 7'd0,   7'd0,  16'd0,   1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 7'd78,  7'd0,  16'd0,   1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 7'd28,  7'd0,  16'd0,   1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 7'd106, 7'd0,  16'd0,   1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 7'd56,  7'd78, 16'd78,  1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 7'd6,   7'd78, 16'd156, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 7'd84,  7'd78, 16'd234, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 7'd34,  7'd78, 16'd312, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 7'd120, 7'd86, 16'd398, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 7'd70,  7'd78, 16'd476, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 7'd33,  7'd91, 16'd567, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 7'd33,  7'd0,  16'd567, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 7'd33,  7'd0,  16'd567, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 7'd33,  7'd0,  16'd567, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 7'd40,  7'd7,  16'd574, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 7'd50,  7'd7,  16'd574, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 7'd60,  7'd7,  16'd574, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 7'd60,  7'd7,  16'd0,   1'b0, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 7'd61,  7'd7,  16'd0,   1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].count);
            chk($sformatf("vec%0d_delta", i), 32'(bus.delta), 32'(vecs[i].delta));
            chk($sformatf("vec%0d_phase", i), 32'(bus.phase), 32'(vecs[i].phase));
            chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vecs[i].stall));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(vecs[i].busy));
            chk($sformatf("vec%0d_oor", i),   32'(bus.out_of_range), 32'd0);
        end

        // Reset in the middle of RUN with phase=500.
        cv = 7'd0;
        start_run(100);
        run_n(5, 100);
        chk("midrun_phase_pre", 32'(bus.phase), 32'd500);
        chk("midrun_valid_pre", 32'(bus.valid), 32'd1);
        step(1'b0, 1'b1, cv + 7'd100);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_delta", 32'(bus.delta), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);

        // Accumulator wrap: 515*127 = 65405, +95 = 65500, +78 wraps to 42.
        cv = 7'd5;
        start_run(127);
        run_n(515, 127);
        chk("accw_phase_65405", 32'(bus.phase), 32'd65405);
        run_n(1, 95);
        chk("accw_phase_65500", 32'(bus.phase), 32'd65500);
        run_n(1, 78);
        chk("accw_phase_42", 32'(bus.phase), 32'd42);
        chk("accw_delta_78", 32'(bus.delta), 32'd78);
        chk("accw_valid", 32'(bus.valid), 32'd1);
        chk("accw_stall", 32'(bus.stall), 32'd0);

`ifdef VPA_RANGE_CHK_EN
        step(1'b1, 1'b0, cv);
        bus.dmin = 7'd70;
        bus.dmax = 7'd90;
        start_run(78);
        run_n(1, 78);
        chk("rng_oor_in",     32'(bus.out_of_range), 32'd0);
        chk("rng_phase_78",   32'(bus.phase), 32'd78);
        run_n(1, 100);
        chk("rng_oor_set",    32'(bus.out_of_range), 32'd1);
        chk("rng_phase_178",  32'(bus.phase), 32'd178);
        chk("rng_delta_100",  32'(bus.delta), 32'd100);
        run_n(1, 78);
        chk("rng_oor_sticky", 32'(bus.out_of_range), 32'd1);
        chk("rng_phase_256",  32'(bus.phase), 32'd256);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vpa_ctrl.md
Name: vpa_ctrl

Overview:
- Controller and readout sequencer for the TDC ripple counter. The counter counts CKV edges and is sampled by the CKV-retimed reference clock.
- Each reference cycle the block:
  - captures the 7-bit free-running ripple count;
  - computes the modulo-128 increment since the previous sample;
  - accumulates it into a wide variable-phase word for the ADPLL phase detector.
- Sequences start-up (warm-up discard) and flags a stalled CKV.

Parameters:
CNT_W, 7, ripple counter width; increments computed modulo 2^CNT_W
ACC_W, 16, variable-phase accumulator width; wraps modulo 2^ACC_W
WARMUP, 4, reference cycles discarded after start before accumulation begins (1..15)
STALL_MAX, 3, consecutive zero increments in RUN that raise stall (1..15)

Ports:
clk  input  1  retimed reference clock; the single clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  run enable; low returns FSM to IDLE on next edge
count  input  CNT_W  ripple counter output, stable at clk edge
delta  output  CNT_W  registered increment (count - prev) mod 2^CNT_W
phase  output  ACC_W  variable-phase accumulator
valid  output  1  one-cycle-per-sample strobe; high in RUN when delta/phase updated
stall  output  1  sticky CKV-stall flag
busy  output  1  high in WARMUP and RUN
out_of_range  output  1  sticky range error (optional feature only; tied 0 otherwise)

Behaviour:
- Reset is synchronous and active-low: on a rising clk edge with rst_n=0, all registers clear.
  - delta=0, phase=0, valid=0, stall=0, busy=0, out_of_range=0.
  - prev=0, warm counter=0, stall counter=0, state=IDLE.
- rst_n has priority over everything, including mid-RUN.
- FSM states: IDLE, WARMUP, RUN.
- IDLE:
  - prev<=count every cycle; phase held; valid=0.
  - en=1 -> WARMUP. Clear the warm counter, clear stall/out_of_range, clear phase to 0.
- WARMUP:
  - prev<=count each cycle; warm counter increments.
  - On the cycle the counter reaches WARMUP-1 -> RUN.
  - en=0 -> IDLE.
  - No accumulation; valid=0.
- RUN, every cycle:
  - d=(count-prev) mod 2^CNT_W (unsigned subtract truncated to CNT_W).
  - delta<=d; phase<=(phase + zero-extended d) mod 2^ACC_W; prev<=count; valid<=1.
  - Latency: count sampled at edge N appears in delta/phase/valid after edge N (registered, 1 cycle).
- First RUN sample uses the prev captured on the last WARMUP cycle, so delta is always a true increment.
- Stall detection:
  - In RUN, d==0 increments the stall counter; d!=0 clears it.
  - When the counter reaches STALL_MAX, stall<=1 (sticky until next IDLE->WARMUP or reset).
  - Accumulation continues while stalled.
- en=0 in RUN:
  - Next edge -> IDLE, valid<=0.
  - phase, delta and stall hold their last values.
- Counter wrap (count < prev) is handled by the modulo subtract; no special case.
- Accumulator wrap is silent; the downstream phase detector uses modulo arithmetic.
- busy is registered and mirrors (state!=IDLE).

Optional Feature:
- Macro VPA_RANGE_CHK_EN.
- When defined:
  - Adds 7-bit inputs dmin and dmax.
  - In RUN, d<dmin or d>dmax sets out_of_range (sticky; cleared on reset or IDLE->WARMUP).
  - phase/delta update unchanged.
- When undefined:
  - dmin/dmax ports absent; out_of_range tied 0.
  - No comparator logic.

Test Plan:
- Reset mid-run: RUN with phase=500, rst_n=0 for one edge -> next cycle phase=0, delta=0, valid=0, busy=0, state IDLE.
- Nominal: en=1, WARMUP=4, count advancing +78 per cycle (mod 128) -> valid first high 5 edges after en; delta=78 each sample; phase=78,156,234 on successive valid cycles.
- Counter wrap: prev=120, count=70 -> delta=78, phase increases by 78; no stall, no out_of_range.
- Accumulator wrap: phase=65500, d=78 -> phase=42.
- Stall: count frozen at 33 in RUN, STALL_MAX=3 -> delta=0 for three samples, stall=1 after third; stays 1 when count resumes; cleared by en 0->1 sequence.
- Range check (VPA_RANGE_CHK_EN, dmin=70, dmax=90): d=78 -> out_of_range=0; d=100 -> out_of_range=1 next edge, sticky; phase still accumulates 100.
